// File: rtl/mem_pkg.sv
// mem_pkg: shared state type and request-direction constants for the main-memory
// responder and the cache controller that drives it.
package mem_pkg;
    typedef enum logic {IDLE, BUSY} mem_state_t;
    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;
    localparam int   CNT_W     = 4;
endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: MStrobe/MRW request bus between the cache controller (master)
// and main memory (slave).
interface main_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              MStrobe;
    logic              MRW;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MDataIn;
    logic [DATA_W-1:0] MDataOut;
    logic              MRdy;
    logic              MBusy;
    logic              MOverrun;
    modport master (
        output MStrobe, MRW, MAddr, MDataIn,
        input  MDataOut, MRdy, MBusy, MOverrun
    );
    modport slave (
        input  MStrobe, MRW, MAddr, MDataIn,
        output MDataOut, MRdy, MBusy, MOverrun
    );
endinterface

// File: rtl/mem_array.sv
// mem_array: word storage with a synchronous write and a registered read port.
// Storage is never reset; only the read register is.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency memory responder; accepts a request in IDLE, waits
// LATENCY cycles, performs the access and pulses MRdy for one cycle.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input logic                 clk,
    input logic                 reset,
    main_mem_responder_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    mem_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              load, done, rdy, overrun;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdy     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rdy     <= done;
            overrun <= overrun | (state == BUSY && bus.MStrobe);
        end
    end
    always_ff @(posedge clk) begin
        if (load) begin
            rw_q   <= bus.MRW;
            addr_q <= bus.MAddr;
            data_q <= bus.MDataIn;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        done    = 1'b0;
        if (state == IDLE) begin
            load    = bus.MStrobe && !reset;
            state_n = bus.MStrobe ? BUSY : IDLE;
            cnt_n   = bus.MStrobe ? CNT_INIT : cnt;
        end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end else begin
            state_n = IDLE;
            done    = !reset;
        end
    end
    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (done && rw_q == MRW_WRITE),
        .re    (done && rw_q == MRW_READ),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (bus.MDataOut)
    );
    assign bus.MRdy     = rdy;
    assign bus.MBusy    = (state == BUSY);
    assign bus.MOverrun = overrun;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed and randomized checks of the responder against a
// word-array reference model, at LATENCY=4 and LATENCY=1.
module tb_main_mem_responder;
    import mem_pkg::*;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int L  = 4;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    logic [DW-1:0] ref_mem [256];
    bit            ref_ok  [256];
    logic [DW-1:0] ref_out;
    bit            ref_ovr;
    logic [AW-1:0] known [$];
    int checks = 0;
    int errors = 0;
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // One request on the LATENCY=4 port, issued in the current cycle; returns in the MRdy cycle.
    task automatic req4(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ovr);
        bus4.MStrobe = 1'b1;
        bus4.MRW     = rw;
        bus4.MAddr   = a;
        bus4.MDataIn = d;
        @(negedge clk);
        bus4.MStrobe = 1'b0;
        for (int c = 1; c <= L; c++) begin
            check("busy", DW'(bus4.MBusy), 1);
            check("rdy_early", DW'(bus4.MRdy), 0);
            check("dout_hold", bus4.MDataOut, ref_out);
            check("ovr_busy", DW'(bus4.MOverrun), DW'(ref_ovr));
            if (ovr && c == 2) begin
                bus4.MStrobe = 1'b1;
                bus4.MRW     = MRW_WRITE;
                bus4.MDataIn = 32'hBAD0BAD0;
                ref_ovr      = 1'b1;
            end
            @(negedge clk);
            bus4.MStrobe = 1'b0;
        end
        if (rw == MRW_WRITE) begin
            ref_mem[a] = d;
            ref_ok[a]  = 1'b1;
            known.push_back(a);
        end else if (ref_ok[a]) begin
            ref_out = ref_mem[a];
        end
        check("rdy", DW'(bus4.MRdy), 1);
        check("busy_done", DW'(bus4.MBusy), 0);
        check("dout", bus4.MDataOut, ref_out);
        check("ovr", DW'(bus4.MOverrun), DW'(ref_ovr));
    endtask
    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_rdy", DW'(bus4.MRdy), 0);
            check("idle_busy", DW'(bus4.MBusy), 0);
        end
    endtask
    initial begin
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus4.MStrobe = 1'b0; bus4.MRW = 1'b0; bus4.MAddr = '0; bus4.MDataIn = '0;
        bus1.MStrobe = 1'b0; bus1.MRW = 1'b0; bus1.MAddr = '0; bus1.MDataIn = '0;
        ref_out = '0;
        ref_ovr = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_rdy", DW'(bus4.MRdy), 0);
        check("rst_busy", DW'(bus4.MBusy), 0);
        check("rst_ovr", DW'(bus4.MOverrun), 0);
        check("rst_dout", bus4.MDataOut, 0);
        check("rst1_dout", bus1.MDataOut, 0);
        // write then read
        req4(MRW_WRITE, 8'h10, 32'hDEADBEEF, 0);
        idle4(1);
        req4(MRW_READ, 8'h10, 32'h0, 0);
        check("wr_rd_data", bus4.MDataOut, 32'hDEADBEEF);
        idle4(2);
        // MDataOut held across a write
        req4(MRW_WRITE, 8'h01, 32'h11, 0);
        req4(MRW_READ, 8'h01, 32'h0, 0);
        req4(MRW_WRITE, 8'h02, 32'h99, 0);
        check("hold_after_wr", bus4.MDataOut, 32'h11);
        idle4(1);
        // LATENCY=1 back-to-back, each strobe in the previous MRdy cycle
        for (int i = 0; i < 8; i++) begin
            bus1.MStrobe = 1'b1;
            bus1.MRW     = (i < 4) ? MRW_WRITE : MRW_READ;
            bus1.MAddr   = AW'(i % 4);
            bus1.MDataIn = DW'(i % 4 + 1);
            @(negedge clk);
            bus1.MStrobe = 1'b0;
            check("b2b_busy", DW'(bus1.MBusy), 1);
            check("b2b_rdy_early", DW'(bus1.MRdy), 0);
            @(negedge clk);
            check("b2b_rdy", DW'(bus1.MRdy), 1);
            check("b2b_dout", bus1.MDataOut, (i < 4) ? DW'(0) : DW'(i - 3));
        end
        @(negedge clk);
        check("b2b_rdy_end", DW'(bus1.MRdy), 0);
        check("b2b_ovr", DW'(bus1.MOverrun), 0);
        // randomized mix, reads restricted to addresses with known contents
        for (int n = 0; n < 40; n++) begin
            rw = (known.size() == 0) ? MRW_WRITE : 1'($urandom_range(0, 1));
            a  = (rw == MRW_WRITE) ? AW'($urandom) : known[$urandom_range(0, known.size() - 1)];
            d  = $urandom;
            req4(rw, a, d, $urandom_range(0, 7) == 0);
            idle4($urandom_range(0, 2));
        end
        // overrun: ignored write must not change the addressed word
        req4(MRW_WRITE, 8'h05, 32'h00C0FFEE, 0);
        idle4(1);
        req4(MRW_READ, 8'h05, 32'h0, 1);
        idle4(3);
        req4(MRW_READ, 8'h05, 32'h0, 0);
        check("ovr_unchanged", bus4.MDataOut, 32'h00C0FFEE);
        check("ovr_sticky", DW'(bus4.MOverrun), 1);
        idle4(1);
        // reset mid-write
        req4(MRW_WRITE, 8'h20, 32'hAAAA0000, 0);
        idle4(1);
        bus4.MStrobe = 1'b1;
        bus4.MRW     = MRW_WRITE;
        bus4.MAddr   = 8'h20;
        bus4.MDataIn = 32'h12345678;
        @(negedge clk);
        bus4.MStrobe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        ref_out = '0;
        ref_ovr = 1'b0;
        check("mid_rst_busy", DW'(bus4.MBusy), 0);
        check("mid_rst_ovr", DW'(bus4.MOverrun), 0);
        check("mid_rst_dout", bus4.MDataOut, 0);
        check("mid_rst_rdy", DW'(bus4.MRdy), 0);
        idle4(5);
        req4(MRW_READ, 8'h20, 32'h0, 0);
        check("mid_rst_keep", bus4.MDataOut, 32'hAAAA0000);
        idle4(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
